// File: rtl/williams_store_if.sv
// Control-unit side of the main store: action-beat access handshake, clear request,
// and the beat/beam status outputs.
interface williams_store_if #(
  parameter int LINE_LENGTH = 40,
  parameter int TA          = 1,
  parameter int WA          = 5
);
  logic                   w_REQ;
  logic                   w_WE;
  logic [TA+WA-1:0]       b_ADDR;
  logic [LINE_LENGTH-1:0] b_ZERO;
  logic [LINE_LENGTH-1:0] b_DATA_IN;
  logic                   w_CLEAR;
  logic                   w_ACK;
  logic [LINE_LENGTH-1:0] b_DATA_OUT;
  logic                   w_HS;
  logic [WA-1:0]          b_SCAN_ADDR;
  logic                   w_BUSY;

  modport master (
    output w_REQ, w_WE, b_ADDR, b_ZERO, b_DATA_IN, w_CLEAR,
    input  w_ACK, b_DATA_OUT, w_HS, b_SCAN_ADDR, w_BUSY
  );

  modport slave (
    input  w_REQ, w_WE, b_ADDR, b_ZERO, b_DATA_IN, w_CLEAR,
    output w_ACK, b_DATA_OUT, w_HS, b_SCAN_ADDR, w_BUSY
  );
endinterface

// File: rtl/williams_store.sv
// Williams-tube style main store: N_TUBES x TUBE_DEPTH lines, an internal scan/action
// beat sequencer, req/ack access on action beats and a beam-driven clear sweep.
module williams_store #(
  parameter  int LINE_LENGTH = 40,
  parameter  int TUBE_DEPTH  = 32,
  parameter  int N_TUBES     = 2,
  parameter  int SCAN_BEATS  = 4,
  localparam int TA          = (N_TUBES > 2) ? $clog2(N_TUBES) : 1,
  localparam int WA          = $clog2(TUBE_DEPTH)
) (
  input  logic              w_CLK,
  input  logic              w_RST_N,
  williams_store_if.slave   bus
);

  localparam int BW = $clog2(SCAN_BEATS + 1);
  localparam int CW = $clog2(TUBE_DEPTH + 1);

  logic [LINE_LENGTH-1:0] r_mem [N_TUBES][TUBE_DEPTH];

  logic [BW-1:0]          r_beat;
  logic [WA-1:0]          r_scan_addr;
  logic [CW-1:0]          r_sweep_cnt;
  logic                   r_busy;
  logic                   r_ack;
  logic [LINE_LENGTH-1:0] r_data_out;

  logic                   w_action;
  logic                   w_serve;
  logic                   w_tube_ok;
  logic [TA-1:0]          w_tube;
  logic [WA-1:0]          w_word;

  assign w_tube    = bus.b_ADDR[TA+WA-1:WA];
  assign w_word    = bus.b_ADDR[WA-1:0];
  assign w_tube_ok = (32'(w_tube) < 32'(N_TUBES));
  assign w_action  = (r_beat == BW'(SCAN_BEATS));
  // Requests are only served on action beats outside a clear sweep.
  assign w_serve   = w_action && bus.w_REQ && !r_busy;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      r_beat      <= '0;
      r_scan_addr <= '0;
      r_sweep_cnt <= '0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_beat <= w_action ? '0 : r_beat + 1'b1;
      if (!w_action)
        r_scan_addr <= (r_scan_addr == WA'(TUBE_DEPTH - 1)) ? '0 : r_scan_addr + 1'b1;

      r_ack <= w_serve;
      if (w_serve && !bus.w_WE)
        r_data_out <= w_tube_ok ? r_mem[w_tube][w_word] : '0;

      // Sweep ends on the edge that zeroes its TUBE_DEPTH-th line.
      if (!r_busy) begin
        if (bus.w_CLEAR) begin
          r_busy      <= 1'b1;
          r_sweep_cnt <= '0;
        end
      end else if (!w_action) begin
        r_sweep_cnt <= r_sweep_cnt + 1'b1;
        if (r_sweep_cnt == CW'(TUBE_DEPTH - 1))
          r_busy <= 1'b0;
      end
    end
  end

  // NOTE: store contents have no reset; a reset mid-sweep leaves partial contents.
  always_ff @(posedge w_CLK) begin
    if (w_serve) begin
      if (bus.w_WE && w_tube_ok)
        r_mem[w_tube][w_word] <= bus.b_DATA_IN | (r_mem[w_tube][w_word] & ~bus.b_ZERO);
    end else if (r_busy && !w_action) begin
      for (int t = 0; t < N_TUBES; t++)
        r_mem[t][r_scan_addr] <= '0;
    end
  end

  assign bus.w_ACK       = r_ack;
  assign bus.b_DATA_OUT  = r_data_out;
  assign bus.w_HS        = !w_action;
  assign bus.b_SCAN_ADDR = r_scan_addr;
  assign bus.w_BUSY      = r_busy;

endmodule
